ptp_intc_multi: RTL

Parametrised multi-source interrupt controller for the PTP subsystem. It replaces the fixed three-input combiner (intxms / rx_ptp / tx_ptp) with one generalised to NUM_SRC sources. New behaviour:
- per-source edge or level mode
- sticky write-1-to-clear status
- software force
- holdoff-based interrupt coalescing

It sits on the 32-bit on-chip bus beside the rx/tx PTP buffers. Its read data is OR-combined with theirs at the NIC level.

---
 rtl/ptp_intc_multi.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ptp_intc_multi.sv
// ptp_intc_multi: NUM_SRC-source interrupt controller for the PTP subsystem.
// Per-source edge/level capture into sticky W1C status, software force,
// global/per-source masking and holdoff-based coalescing of int_o.
module ptp_intc_multi #(
    parameter int unsigned NUM_SRC       = 4,
    parameter logic [31:0] INT_BASE_ADDR = 32'h300,
    parameter int unsigned COAL_W        = 16
) (
    input  logic               bus2ip_clk,
    input  logic               bus2ip_rst_n,
    input  logic [31:0]        bus2ip_addr_i,
    input  logic [31:0]        bus2ip_data_i,
    input  logic               bus2ip_rd_ce_i,
    input  logic               bus2ip_wr_ce_i,
    output logic [31:0]        ip2bus_data_o,
    input  logic [NUM_SRC-1:0] int_src_i,
    output logic               int_o
);
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    localparam logic [2:0] OFF_RAW     = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_ENABLE  = 3'd2;
    localparam logic [2:0] OFF_MODE    = 3'd3;
    localparam logic [2:0] OFF_HOLDOFF = 3'd4;
    localparam logic [2:0] OFF_CTRL    = 3'd5;
    localparam logic [2:0] OFF_FORCE   = 3'd6;

    logic [NUM_SRC-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [NUM_SRC-1:0] status_q, status_d, enable_q, enable_d, mode_q, mode_d;
    logic [COAL_W-1:0]  holdoff_q, holdoff_d, cnt_q, cnt_d;
    logic               gie_q, gie_d;
    logic [1:0]         state_q, state_d;
    logic               int_q, int_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               sel_c, rd_c, wr_c, pending_c;
    logic [2:0]         off_c;
    logic [NUM_SRC-1:0] wdata_src_c, w1c_c, force_c, set_c;
    logic               unused_ok;

    // Byte-lane address bits and write-data bits above the widest field are don't-care.
    assign unused_ok = ^{bus2ip_addr_i[1:0], bus2ip_data_i};

    // Address decode, register writes, status set/clear and read-data mux.
    always_comb begin
        sel_c       = (bus2ip_addr_i[31:5] == INT_BASE_ADDR[31:5]);
        off_c       = bus2ip_addr_i[4:2];
        rd_c        = bus2ip_rd_ce_i & sel_c;
        wr_c        = bus2ip_wr_ce_i & sel_c;
        wdata_src_c = bus2ip_data_i[NUM_SRC-1:0];
        s1_d        = int_src_i;
        s2_d        = s1_q;
        s3_d        = s2_q;
        enable_d    = enable_q;
        mode_d      = mode_q;
        holdoff_d   = holdoff_q;
        gie_d       = gie_q;
        w1c_c       = '0;
        force_c     = '0;
        if (wr_c) begin
            case (off_c)
                OFF_STATUS:  w1c_c     = wdata_src_c;
                OFF_ENABLE:  enable_d  = wdata_src_c;
                OFF_MODE:    mode_d    = wdata_src_c;
                OFF_HOLDOFF: holdoff_d = bus2ip_data_i[COAL_W-1:0];
                OFF_CTRL:    gie_d     = bus2ip_data_i[0];
                OFF_FORCE:   force_c   = wdata_src_c;
                default:     ;
            endcase
        end
        // Set beats clear; a level source still high simply re-sets its bit.
        set_c    = (s2_q & ~s3_q & mode_q) | (s2_q & ~mode_q) | force_c;
        status_d = set_c | (status_q & ~w1c_c);
        rdata_d  = '0;
        if (rd_c) begin
            case (off_c)
                OFF_RAW:     rdata_d = DATA_W'(s2_q);
                OFF_STATUS:  rdata_d = DATA_W'(status_q);
                OFF_ENABLE:  rdata_d = DATA_W'(enable_q);
                OFF_MODE:    rdata_d = DATA_W'(mode_q);
                OFF_HOLDOFF: rdata_d = DATA_W'(holdoff_q);
                OFF_CTRL:    rdata_d = DATA_W'(gie_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    // Output FSM: assert while pending, then optionally hold off for HOLDOFF cycles.
    always_comb begin
        pending_c = gie_q & (|(status_q & enable_q));
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_c) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (!pending_c) begin
                    if (holdoff_q != '0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = holdoff_q - COAL_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - COAL_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        int_d = (state_d == ST_ASSERT);
    end

    // Synchroniser, register file and read-data register.
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            status_q  <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            holdoff_q <= '0;
            gie_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            status_q  <= status_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            holdoff_q <= holdoff_d;
            gie_q     <= gie_d;
            rdata_q   <= rdata_d;
        end
    end

    // FSM state, holdoff counter and registered interrupt output.
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
        end
    end

    assign ip2bus_data_o = rdata_q;
    assign int_o         = int_q;

endmodule
